ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Two-master arbiter and sequencer for the shared single-port `ram` block, for example instruction-side and data-side caches.
- Grants one request at a time, round-robin.
- Drives the ram address/data/write inputs, then tracks the ram `response` busy pulse to detect completion.
- Returns read data with a one-cycle ack per master.
- Masks the ram's "ignore unchanged inputs" behaviour with a same-request bypass and a busy timeout.

Parameters:
- RAM_SIZE, 4096, word depth of the attached ram; addresses are compared modulo RAM_SIZE.
- BUSY_TIMEOUT, 4, WAIT_BUSY cycles with response low before the transaction is treated as done. Legal minimum 3.

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- m0_req  in  1  master 0 request; held with fields stable until m0_ack
- m0_write  in  1  1 = write, 0 = read
- m0_address  in  32  word address
- m0_data  in  32  write data
- m0_ack  out  1  one-cycle completion pulse
- m0_rdata  out  32  read data, valid with ack, held until next m0_ack
- m1_req, m1_write, m1_address, m1_data, m1_ack, m1_rdata  same as m0, for master 1
- ram_address  out  32  to ram.address (registered)
- ram_data  out  32  to ram.data (registered)
- ram_write  out  1  to ram.write (registered)
- ram_response  in  1  from ram.response; 1 = busy
- ram_out  in  32  from ram.out
- busy  out  1  high in every state except IDLE
- grant  out  1  master currently or last served (0/1)

Behaviour:
- Reset, synchronous, active-high:
  - state = IDLE; both acks = 0; both rdata = 0.
  - ram_address/ram_data/ram_write = 0, matching the ram's power-up previous-value registers.
  - last_valid = 0; rr pointer set so m0 wins the first tie; grant = 0; cnt = 0.
- Reset mid-transaction: the transaction is abandoned with no ack. The requester keeps req high and is re-served after reset. Driving zeros causes the ram to do one harmless read of address 0.
- IDLE:
  - Sample m0_req and m1_req.
  - Single request: grant it.
  - Both requesting: grant the master other than the one served last, then flip the pointer.
  - On grant, if last_valid and (address mod RAM_SIZE, data, write) equals the last issued triple: bypass. Go to ACK with rdata = ram_out. Ram outputs unchanged; no ram access.
  - Otherwise load ram_address = address, ram_data = data, ram_write = write, save the triple, cnt = 0, go to WAIT_BUSY.
- WAIT_BUSY:
  - ram_response = 1 → WAIT_DONE.
  - Else cnt += 1; if cnt reaches BUSY_TIMEOUT, go to ACK (ram saw no change; ram_out already reflects this triple).
- WAIT_DONE:
  - ram_response = 0 → capture ram_out into the granted master's rdata (reads only; writes leave rdata unchanged), go to ACK.
  - No timeout in this state.
- ACK:
  - Granted master's ack = 1 for exactly this cycle; last_valid = 1; go to IDLE.
  - Requests are not sampled in ACK, so a master that drops or changes req after seeing ack is never double-served.
- Normal latency, grant edge E0:
  - E1: ram latches the new inputs.
  - E2: arbiter samples response = 1.
  - E3: arbiter samples response = 0 and ack rises.
  - E4: ack falls, back in IDLE.
  - Total: ack 3 edges after grant, 4 cycles per transaction.
- Bypass latency: ack 1 edge after grant.
- Timeout latency: ack BUSY_TIMEOUT + 1 edges after grant.
- Ram interface rules:
  - ram_* outputs change only on a grant edge or on reset; they are stable otherwise.
  - ram_out is sampled only at the WAIT_DONE → ACK transition or on bypass.
- Starvation: with both masters requesting continuously, grants strictly alternate.
- A req deasserted before a grant is simply not served. Dropping req after grant is illegal (undefined).
- Address bits at or above log2(RAM_SIZE) are ignored in the bypass compare, because the ram aliases them.

Test Plan:
- Reset, then m0 writes addr 0x10, data 0xDEADBEEF → ram_write = 1 and ram_address = 0x10 after E0; m0_ack high for one cycle 3 edges after grant; ram[0x10] = 0xDEADBEEF.
- m1 reads 0x10 after the write → m1_ack 3 edges after grant; m1_rdata = 0xDEADBEEF; m0_rdata unchanged.
- m0 and m1 request together (m0 write 0x20 = 5, m1 read 0x20) with m0 served last → m1 served first and reads the prior contents; m0 next; grant sequence 1,0; the following tie goes to 1.
- m1 repeats the identical read of 0x10 immediately → bypass: ack 1 edge after grant, rdata = 0xDEADBEEF, ram_* unchanged, ram_response stays 0. Same read of 0x1010 (aliases mod 4096) → also bypass.
- After reset, m0 reads addr 0 with data 0 → ram sees no change; ack after BUSY_TIMEOUT + 1 = 5 edges; no hang.
- Assert reset while in WAIT_DONE → next cycle: IDLE, acks 0, rdata 0, ram_* = 0. The held req is re-served from scratch with a normal 3-edge ack.

Source files
------------

// File: rtl/ram_arbiter.sv
// Two-master round-robin arbiter and sequencer for the shared single-port ram.
// Hides the ram's "ignore unchanged inputs" behaviour with a bypass and a busy timeout.
module ram_arbiter #(
  parameter int RAM_SIZE     = 4096,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_write,
  input  logic [31:0] m0_address,
  input  logic [31:0] m0_data,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_write,
  input  logic [31:0] m1_address,
  input  logic [31:0] m1_data,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic [31:0] ram_address,
  output logic [31:0] ram_data,
  output logic        ram_write,
  input  logic        ram_response,
  input  logic [31:0] ram_out,
  output logic        busy,
  output logic        grant
);

  localparam int CW = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE, ACK} state_t;

  state_t        state, state_next;
  logic          rr;
  logic          cur_write;
  logic          last_valid;
  logic          last_write;
  logic [31:0]   last_addr;
  logic [31:0]   last_data;
  logic [CW-1:0] cnt;

  logic          sel;
  logic          sel_write;
  logic [31:0]   sel_addr;
  logic [31:0]   sel_data;
  logic          hit;
  logic          do_grant;
  logic          do_load;
  logic          cnt_inc;
  logic          capture;

  // rr holds the master preferred on a tie; a lone requester always wins.
  assign sel       = (m0_req && m1_req) ? rr : m1_req;
  assign sel_write = sel ? m1_write   : m0_write;
  assign sel_addr  = sel ? m1_address : m0_address;
  assign sel_data  = sel ? m1_data    : m0_data;

  assign hit = last_valid
            && ((sel_addr % 32'(RAM_SIZE)) == last_addr)
            && (sel_data == last_data)
            && (sel_write == last_write);

  assign busy   = (state != IDLE);
  assign m0_ack = (state == ACK) && !grant;
  assign m1_ack = (state == ACK) && grant;

  // Bypass and timeout both funnel through WAIT_DONE so ram_out is captured
  // in one place; the ram is idle there, so response is already low.
  always_comb begin
    state_next = state;
    do_grant   = 1'b0;
    do_load    = 1'b0;
    cnt_inc    = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (m0_req || m1_req) begin
          do_grant = 1'b1;
          if (hit) begin
            state_next = WAIT_DONE;
          end else begin
            do_load    = 1'b1;
            state_next = WAIT_BUSY;
          end
        end
      end
      WAIT_BUSY: begin
        if (ram_response) begin
          state_next = WAIT_DONE;
        end else begin
          cnt_inc = 1'b1;
          if (cnt == CW'(BUSY_TIMEOUT - 1)) state_next = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!ram_response) begin
          capture    = 1'b1;
          state_next = ACK;
        end
      end
      ACK: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rr          <= 1'b0;
      grant       <= 1'b0;
      cur_write   <= 1'b0;
      cnt         <= '0;
      last_valid  <= 1'b0;
      last_write  <= 1'b0;
      last_addr   <= '0;
      last_data   <= '0;
      ram_address <= '0;
      ram_data    <= '0;
      ram_write   <= 1'b0;
      m0_rdata    <= '0;
      m1_rdata    <= '0;
    end else begin
      state <= state_next;
      if (do_grant) begin
        grant     <= sel;
        rr        <= ~sel;
        cur_write <= sel_write;
        cnt       <= '0;
      end
      if (do_load) begin
        ram_address <= sel_addr;
        ram_data    <= sel_data;
        ram_write   <= sel_write;
        last_addr   <= sel_addr % 32'(RAM_SIZE);
        last_data   <= sel_data;
        last_write  <= sel_write;
      end
      if (cnt_inc) cnt <= cnt + 1'b1;
      if (capture && !cur_write) begin
        if (grant) m1_rdata <= ram_out;
        else       m0_rdata <= ram_out;
      end
      if (state == ACK) last_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter with a behavioural model of the shared ram
// (one-cycle busy pulse, ignores unchanged inputs).
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m0_req = 1'b0, m0_write = 1'b0;
  logic [31:0] m0_address = '0, m0_data = '0;
  logic        m0_ack;
  logic [31:0] m0_rdata;
  logic        m1_req = 1'b0, m1_write = 1'b0;
  logic [31:0] m1_address = '0, m1_data = '0;
  logic        m1_ack;
  logic [31:0] m1_rdata;
  logic [31:0] ram_address, ram_data;
  logic        ram_write;
  logic        ram_response = 1'b0;
  logic [31:0] ram_out = '0;
  logic        busy, grant;

  ram_arbiter #(.RAM_SIZE(4096), .BUSY_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_write(m0_write), .m0_address(m0_address), .m0_data(m0_data),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_write(m1_write), .m1_address(m1_address), .m1_data(m1_data),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .ram_address(ram_address), .ram_data(ram_data), .ram_write(ram_write),
    .ram_response(ram_response), .ram_out(ram_out),
    .busy(busy), .grant(grant)
  );

  always #5 clk = ~clk;

  // Ram model: acts only when its inputs differ from those it saw last.
  logic [31:0] mem [0:4095] = '{default: 32'h0};
  logic [31:0] prev_address = '0, prev_data = '0;
  logic        prev_write = 1'b0;

  always @(posedge clk) begin
    if (ram_address != prev_address || ram_data != prev_data || ram_write != prev_write) begin
      prev_address <= ram_address;
      prev_data    <= ram_data;
      prev_write   <= ram_write;
      ram_response <= 1'b1;
      if (ram_write) begin
        mem[ram_address[11:0]] <= ram_data;
        ram_out                <= ram_data;
      end else begin
        ram_out <= mem[ram_address[11:0]];
      end
    end else begin
      ram_response <= 1'b0;
    end
  end

  typedef struct {
    int          master;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: latency is measured from the edge where busy first rises.
  initial begin
    int   grant_cyc;
    logic prev_busy;
    exp_t e;
    grant_cyc = 0;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (busy && !prev_busy) grant_cyc = cyc;
      prev_busy = busy;
      if (m0_ack || m1_ack) begin
        checkOutput("ack_exclusive", 32'(m0_ack && m1_ack), 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_ack: got m0_ack=%0b m1_ack=%0b, expected none", m0_ack, m1_ack);
        end else begin
          e = exp_q.pop_front();
          checkOutput("ack_master", 32'(m1_ack), 32'(e.master));
          checkOutput("grant", 32'(grant), 32'(e.master));
          checkOutput("rdata", m1_ack ? m1_rdata : m0_rdata, e.rdata);
          checkOutput("latency", 32'(cyc - grant_cyc), 32'(e.lat));
        end
      end
    end
  end

  task automatic applyStimulus(input int m, input logic w, input logic [31:0] a, input logic [31:0] d,
                               input logic [31:0] exp_rdata, input int lat);
    exp_t e;
    e.master = m;
    e.rdata  = exp_rdata;
    e.lat    = lat;
    exp_q.push_back(e);
    if (m == 0) begin
      m0_write = w; m0_address = a; m0_data = d; m0_req = 1'b1;
    end else begin
      m1_write = w; m1_address = a; m1_data = d; m1_req = 1'b1;
    end
  endtask

  task automatic waitAck(input int m, output logic resp_seen);
    logic done;
    resp_seen = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (ram_response) resp_seen = 1'b1;
      if ((m == 0 && m0_ack) || (m == 1 && m1_ack)) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL ack_timeout: got no ack from m%0d, expected one within 40 cycles", m);
    end
    if (m == 0) m0_req = 1'b0;
    else        m1_req = 1'b0;
  endtask

  task automatic waitBusy();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (busy) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL busy_timeout: got busy=0, expected 1 within 20 cycles");
    end
  endtask

  task automatic checkResetState();
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_acks", 32'({m0_ack, m1_ack}), 32'd0);
    checkOutput("rst_m0_rdata", m0_rdata, 32'h0);
    checkOutput("rst_m1_rdata", m1_rdata, 32'h0);
    checkOutput("rst_ram_address", ram_address, 32'h0);
    checkOutput("rst_ram_data", ram_data, 32'h0);
    checkOutput("rst_ram_write", 32'(ram_write), 32'd0);
  endtask

  initial begin
    logic rs;
    repeat (2) @(negedge clk);
    checkResetState();
    checkOutput("rst_grant", 32'(grant), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // m0 write, normal 3-edge transaction
    applyStimulus(0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 3);
    waitBusy();
    checkOutput("t1_ram_write", 32'(ram_write), 32'd1);
    checkOutput("t1_ram_address", ram_address, 32'h10);
    checkOutput("t1_ram_data", ram_data, 32'hDEADBEEF);
    waitAck(0, rs);
    checkOutput("t1_mem", mem[12'h10], 32'hDEADBEEF);

    applyStimulus(1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 3);
    waitAck(1, rs);
    checkOutput("t2_m0_rdata_kept", m0_rdata, 32'h0);

    // identical and aliased reads are bypassed without touching the ram
    applyStimulus(1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1);
    waitAck(1, rs);
    checkOutput("t4_no_response", 32'(rs), 32'd0);
    checkOutput("t4_ram_address", ram_address, 32'h10);
    checkOutput("t4_ram_write", 32'(ram_write), 32'd0);
    applyStimulus(1, 1'b0, 32'h1010, 32'h0, 32'hDEADBEEF, 1);
    waitAck(1, rs);
    checkOutput("t4_alias_no_response", 32'(rs), 32'd0);
    checkOutput("t4_alias_ram_address", ram_address, 32'h10);
    applyStimulus(0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1);
    waitAck(0, rs);

    // tie with m0 served last: m1 first, then m0
    applyStimulus(1, 1'b0, 32'h20, 32'h0, 32'h0, 3);
    applyStimulus(0, 1'b1, 32'h20, 32'h5, 32'hDEADBEEF, 3);
    waitAck(1, rs);
    waitAck(0, rs);
    checkOutput("t6_mem", mem[12'h20], 32'h5);

    // next tie goes to m1 again
    applyStimulus(1, 1'b0, 32'h20, 32'h0, 32'h5, 3);
    applyStimulus(0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 3);
    waitAck(1, rs);
    waitAck(0, rs);

    // timeout path: ram sees its power-up triple again
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checkResetState();
    repeat (3) @(negedge clk);
    applyStimulus(0, 1'b0, 32'h0, 32'h0, 32'h0, 5);
    waitAck(0, rs);
    checkOutput("t8_no_response", 32'(rs), 32'd0);

    // reset while in WAIT_DONE abandons the transaction
    applyStimulus(1, 1'b0, 32'h20, 32'h0, 32'h5, 3);
    waitBusy();
    repeat (2) @(negedge clk);
    checkOutput("t9_ram_address", ram_address, 32'h20);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkResetState();
    waitAck(1, rs);

    repeat (3) @(negedge clk);
    checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
